// File: rtl/bin_gray_counter_pkg.sv
// rtl/bin_gray_counter_pkg.sv - shared mode encoding and bit-count helper for the Gray counter
package bin_gray_counter_pkg;

  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_STEP = 2'd1,
    MODE_LOAD = 2'd2
  } mode_e;

  function automatic logic [4:0] popcount16(input logic [MAX_W-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bin_gray_counter_if.sv
// rtl/bin_gray_counter_if.sv - control and count bundle between a driver and the Gray counter
interface bin_gray_counter_if #(
  parameter int W = 4
);
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         tc;
  logic         step_err;

  modport master (
    output en, up, load, load_bin,
    input  bin, gray, tc, step_err
  );

  modport slave (
    input  en, up, load, load_bin,
    output bin, gray, tc, step_err
  );
endinterface

// File: rtl/bin_gray_counter_bin2gray.sv
// rtl/bin_gray_counter_bin2gray.sv - combinational binary to Gray encoder
module bin2gray_comb #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);
  assign o_gray = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/bin_gray_counter.sv
// rtl/bin_gray_counter.sv - registered binary/Gray up/down counter with load, wrap pulse and step checker
module bin_gray_counter
  import bin_gray_counter_pkg::*;
#(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  bin_gray_counter_if.slave   bus
);
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

  logic [W-1:0] r_bin;
  logic [W-1:0] r_gray;
  logic         r_tc;
  logic         r_step_err;

  logic [W-1:0] w_bin_nxt;
  logic [W-1:0] w_gray_nxt;
  logic [W-1:0] w_gray_load;
  logic         w_wrap;
  logic         w_step_bad;
  mode_e        w_mode;

  assign w_bin_nxt = bus.up ? (r_bin + ONE) : (r_bin - ONE);
  assign w_wrap    = bus.up ? (r_bin == {W{1'b1}}) : (r_bin == '0);

  // Gray of the next value, so bin and gray always land in the same cycle
  bin2gray_comb #(.W(W)) u_b2g_step (.i_bin(w_bin_nxt),    .o_gray(w_gray_nxt));
  bin2gray_comb #(.W(W)) u_b2g_load (.i_bin(bus.load_bin), .o_gray(w_gray_load));

  assign w_step_bad = (popcount16(MAX_W'(w_gray_nxt ^ r_gray)) != 5'd1);

  always_comb begin
    w_mode = MODE_HOLD;
    if (bus.load) begin
      w_mode = MODE_LOAD;
    end else if (bus.en) begin
      w_mode = MODE_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin      <= RST_VAL;
      r_gray     <= RST_GRAY;
      r_tc       <= 1'b0;
      r_step_err <= 1'b0;
    end else begin
      case (w_mode)
        MODE_LOAD: begin
          r_bin  <= bus.load_bin;
          r_gray <= w_gray_load;
          r_tc   <= 1'b0;
        end
        MODE_STEP: begin
          r_bin      <= w_bin_nxt;
          r_gray     <= w_gray_nxt;
          r_tc       <= w_wrap;
          r_step_err <= r_step_err | w_step_bad;
        end
        default: begin
          r_tc <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bin      = r_bin;
  assign bus.gray     = r_gray;
  assign bus.tc       = r_tc;
  assign bus.step_err = r_step_err;
endmodule

// File: tb/tb_bin_gray_counter.sv
// tb/tb_bin_gray_counter.sv - self-checking bench for bin_gray_counter (vector table plus random scoreboard run)
module tb_bin_gray_counter;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bin_gray_counter_if #(.W(W)) bus ();
  bin_gray_counter_if #(.W(W)) bus5 ();

  bin_gray_counter #(.W(W), .RST_VAL(4'd0)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  bin_gray_counter #(.W(W), .RST_VAL(4'd5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  typedef struct {
    logic       rst_n;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] load_bin;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
  } vec_t;

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void add(input logic r, input logic ld, input logic e, input logic u,
                              input logic [3:0] lb, input logic [3:0] b, input logic [3:0] g,
                              input logic t);
    vec_t v;
    v.rst_n = r; v.load = ld; v.en = e; v.up = u; v.load_bin = lb;
    v.bin = b; v.gray = g; v.tc = t;
    vecs.push_back(v);
  endfunction

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic r, input logic ld, input logic e, input logic u, input logic [3:0] lb);
    @(negedge clk);
    rst_n        = r;
    bus.load     = ld;
    bus.en       = e;
    bus.up       = u;
    bus.load_bin = lb;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_sb: got empty scoreboard, expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_bin"},  32'(bus.bin),      32'(e.bin));
      check({tag, "_gray"}, 32'(bus.gray),     32'(e.gray));
      check({tag, "_tc"},   32'(bus.tc),       32'(e.tc));
      check({tag, "_err"},  32'(bus.step_err), 32'(e.err));
      check({tag, "_dec"},  32'(gray2bin(bus.gray)), 32'(bus.bin));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m_bin;
    logic       m_tc;
    logic       ld, e, u;
    logic [3:0] lb;
    logic [3:0] prev_gray;
    exp_t       x;

    rst_n = 1'b0;
    bus.load = 1'b0; bus.en = 1'b0; bus.up = 1'b0; bus.load_bin = '0;
    bus5.load = 1'b0; bus5.en = 1'b0; bus5.up = 1'b0; bus5.load_bin = '0;

    // Reset, then 16 increments through the wrap
    add(0,0,0,0,4'h0, 4'h0,4'b0000,0);
    add(1,0,1,1,4'h0, 4'h1,4'b0001,0);
    add(1,0,1,1,4'h0, 4'h2,4'b0011,0);
    add(1,0,1,1,4'h0, 4'h3,4'b0010,0);
    add(1,0,1,1,4'h0, 4'h4,4'b0110,0);
    add(1,0,1,1,4'h0, 4'h5,4'b0111,0);
    add(1,0,1,1,4'h0, 4'h6,4'b0101,0);
    add(1,0,1,1,4'h0, 4'h7,4'b0100,0);
    add(1,0,1,1,4'h0, 4'h8,4'b1100,0);
    add(1,0,1,1,4'h0, 4'h9,4'b1101,0);
    add(1,0,1,1,4'h0, 4'hA,4'b1111,0);
    add(1,0,1,1,4'h0, 4'hB,4'b1110,0);
    add(1,0,1,1,4'h0, 4'hC,4'b1010,0);
    add(1,0,1,1,4'h0, 4'hD,4'b1011,0);
    add(1,0,1,1,4'h0, 4'hE,4'b1001,0);
    add(1,0,1,1,4'h0, 4'hF,4'b1000,0);
    add(1,0,1,1,4'h0, 4'h0,4'b0000,1);
    // Load 1010 then count down three
    add(1,1,0,0,4'hA, 4'hA,4'b1111,0);
    add(1,0,1,0,4'h0, 4'h9,4'b1101,0);
    add(1,0,1,0,4'h0, 4'h8,4'b1100,0);
    add(1,0,1,0,4'h0, 4'h7,4'b0100,0);
    // Reset to 0, down-wrap, then hold
    add(0,0,0,0,4'h0, 4'h0,4'b0000,0);
    add(1,0,1,0,4'h0, 4'hF,4'b1000,1);
    add(1,0,0,0,4'h0, 4'hF,4'b1000,0);
    add(1,0,0,1,4'h0, 4'hF,4'b1000,0);
    add(1,0,0,0,4'h3, 4'hF,4'b1000,0);
    // Load beats en
    add(1,1,1,1,4'h7, 4'h7,4'b0100,0);
    // Direction toggle 5 -> 6 -> 5
    add(1,1,0,0,4'h5, 4'h5,4'b0111,0);
    add(1,0,1,1,4'h0, 4'h6,4'b0101,0);
    add(1,0,1,0,4'h0, 4'h5,4'b0111,0);
    // Reset beats load and en mid-count
    add(1,1,0,0,4'hC, 4'hC,4'b1010,0);
    add(0,1,1,1,4'hF, 4'h0,4'b0000,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].load_bin);
      x.bin = vecs[i].bin; x.gray = vecs[i].gray; x.tc = vecs[i].tc; x.err = 1'b0;
      sb.push_back(x);
      @(posedge clk); #1;
      compare_out($sformatf("vec%0d", i));
      if (i == 0) begin
        check("rst5_bin",  32'(bus5.bin),  32'h5);
        check("rst5_gray", 32'(bus5.gray), 32'h7);
        check("rst5_tc",   32'(bus5.tc),   32'h0);
      end
    end

    m_bin     = 4'h0;
    prev_gray = bus.gray;
    for (int c = 0; c < 1000; c++) begin
      ld = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 2) != 0);
      u  = 1'($urandom_range(0, 1));
      lb = 4'($urandom_range(0, 15));
      drive(1'b1, ld, e, u, lb);
      if (ld) begin
        m_bin = lb;
        m_tc  = 1'b0;
      end else if (e) begin
        m_tc  = u ? (m_bin == 4'hF) : (m_bin == 4'h0);
        m_bin = u ? m_bin + 4'h1 : m_bin - 4'h1;
      end else begin
        m_tc = 1'b0;
      end
      x.bin = m_bin; x.gray = m_bin ^ (m_bin >> 1); x.tc = m_tc; x.err = 1'b0;
      sb.push_back(x);
      @(posedge clk); #1;
      compare_out($sformatf("rnd%0d", c));
      if (e && !ld) check($sformatf("rnd%0d_onebit", c), 32'($countones(bus.gray ^ prev_gray)), 32'd1);
      prev_gray = bus.gray;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
